// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t        - sequencer state encoding
//   DEFAULT_HALT_OPCODE  - opcode that stops the sequencer unless overridden
//   WATCHDOG_WIDTH       - width of the memory wait counter
//   is_bus_state()       - true in states that drive the memory read request
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } fetch_state_t;

    localparam logic [7:0] DEFAULT_HALT_OPCODE = 8'hFF;
    localparam int         WATCHDOG_WIDTH      = 8;

    // ADDR and WAIT are the only states that own the address bus.
    function automatic logic is_bus_state(input fetch_state_t s);
        return (s == ST_ADDR) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog
// Counts memory wait cycles and flags a timeout on the LIMIT-th
// consecutive cycle without data.
// Parameters:
//   LIMIT   - number of enabled cycles that produce a timeout (1..255)
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset
//   clear   - synchronous counter clear (held outside the wait state)
//   enable  - count this cycle (waiting and no data returned)
//   timeout - combinational, high on the enabled cycle that reaches LIMIT
module fetch_watchdog
    import fetch_ctrl_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [WATCHDOG_WIDTH-1:0] LAST  = WATCHDOG_WIDTH'(LIMIT - 1);
    localparam logic [WATCHDOG_WIDTH-1:0] MAXED = '1;

    logic [WATCHDOG_WIDTH-1:0] count;

    // Counter holds at its maximum so it can never wrap back to a
    // value below LAST while the sequencer is still waiting.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != MAXED)) begin
            count <= count + WATCHDOG_WIDTH'(1);
        end
    end

    // The cycle that would bring the count to LIMIT is the timeout cycle.
    assign timeout = enable && (count == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction fetch sequencer: requests a byte from memory, latches it into
// the instruction register, strobes decode, waits for the execute unit and
// steers the program counter (increment after a fetch, load on a jump).
// A memory watchdog halts the sequencer with a sticky fault flag when
// memory fails to answer; fetching HALT_OPCODE halts it cleanly.
// Configuration macro:
//   FETCH_CTRL_STEP_EN - adds input i_step; a pulse while idle with i_run
//                        low fetches and executes a single instruction.
// Parameters:
//   MEM_TIMEOUT  - wait cycles without i_mem_ready before fault (1..255)
//   HALT_OPCODE  - opcode that halts the sequencer
// Ports:
//   i_clk, i_reset        - clock, synchronous active-high reset
//   i_step                - single-step request (macro builds only)
//   i_run                 - level, permits fetching
//   i_mem_ready           - memory data valid
//   i_mem_data[7:0]       - instruction byte
//   i_exec_done           - execute unit finished
//   i_jump                - with i_exec_done, take branch
//   i_jump_target[7:0]    - branch address
//   o_mem_rd              - memory read request
//   o_pc_noe              - PC address-bus enable, active-low
//   o_pc_incr, o_pc_load  - PC increment / load strobes
//   o_pc_data[7:0]        - PC load value
//   o_ir[7:0], o_ir_valid - instruction register, one-cycle decode strobe
//   o_halted, o_fault     - halt state, sticky timeout fault
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [7:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic       i_clk,
    input  logic       i_reset,
`ifdef FETCH_CTRL_STEP_EN
    input  logic       i_step,
`endif
    input  logic       i_run,
    input  logic       i_mem_ready,
    input  logic [7:0] i_mem_data,
    input  logic       i_exec_done,
    input  logic       i_jump,
    input  logic [7:0] i_jump_target,
    output logic       o_mem_rd,
    output logic       o_pc_noe,
    output logic       o_pc_incr,
    output logic       o_pc_load,
    output logic [7:0] o_pc_data,
    output logic [7:0] o_ir,
    output logic       o_ir_valid,
    output logic       o_halted,
    output logic       o_fault
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic wd_enable;
    logic wd_timeout;
    logic ir_capture;
    logic fault_set;

    fetch_watchdog #(
        .LIMIT   (MEM_TIMEOUT)
    ) u_watchdog (
        .clk     (i_clk),
        .reset   (i_reset),
        .clear   (state != ST_WAIT),
        .enable  (wd_enable),
        .timeout (wd_timeout)
    );

`ifdef FETCH_CTRL_STEP_EN
    // Remembers that the current instruction was started by i_step so the
    // sequencer returns to IDLE after it, whatever i_run does meanwhile.
    logic step_mode;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            step_mode <= 1'b0;
        end else if (state == ST_IDLE) begin
            step_mode <= i_step && !i_run;
        end
    end
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register loads only when memory answers in WAIT.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ir <= 8'h00;
        end else if (ir_capture) begin
            o_ir <= i_mem_data;
        end
    end

    // Fault flag is sticky; HALT is only left through reset anyway.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_fault <= 1'b0;
        end else if (fault_set) begin
            o_fault <= 1'b1;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_next = state;
        o_mem_rd   = 1'b0;
        o_pc_noe   = 1'b1;
        o_pc_incr  = 1'b0;
        o_pc_load  = 1'b0;
        o_pc_data  = 8'h00;
        o_ir_valid = 1'b0;
        wd_enable  = 1'b0;
        ir_capture = 1'b0;
        fault_set  = 1'b0;

        if (is_bus_state(state)) begin
            o_mem_rd = 1'b1;
            o_pc_noe = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (i_run) begin
                    state_next = ST_ADDR;
`ifdef FETCH_CTRL_STEP_EN
                end else if (i_step) begin
                    state_next = ST_ADDR;
`endif
                end
            end

            ST_ADDR: begin
                state_next = ST_WAIT;
            end

            // Data arriving on the timeout cycle still wins: the fetch
            // succeeded, so no fault is raised.
            ST_WAIT: begin
                if (i_mem_ready) begin
                    ir_capture = 1'b1;
                    o_pc_incr  = 1'b1;
                    state_next = ST_DECODE;
                end else begin
                    wd_enable = 1'b1;
                    if (wd_timeout) begin
                        fault_set  = 1'b1;
                        state_next = ST_HALT;
                    end
                end
            end

            ST_DECODE: begin
                o_ir_valid = 1'b1;
                if (o_ir == HALT_OPCODE) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_EXEC;
                end
            end

            // i_jump means nothing until the execute unit reports done.
            ST_EXEC: begin
                if (i_exec_done) begin
                    if (i_jump) begin
                        o_pc_load = 1'b1;
                        o_pc_data = i_jump_target;
                    end
`ifdef FETCH_CTRL_STEP_EN
                    if (step_mode) begin
                        state_next = ST_IDLE;
                    end else if (i_run) begin
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_IDLE;
                    end
`else
                    if (i_run) begin
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_IDLE;
                    end
`endif
                end
            end

            ST_HALT: begin
                state_next = ST_HALT;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_halted = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. The stimulus thread pushes the events it
// expects (PC increment, decode strobe with opcode, PC load with target,
// halt entry with fault flag) into a queue; a monitor pops and compares
// whenever the DUT shows one of those events. Define FETCH_CTRL_STEP_EN
// to also exercise the single-step input.
module tb_fetch_ctrl;

    typedef enum logic [1:0] {EV_INCR, EV_IRV, EV_LOAD, EV_HALT} ev_kind_t;

    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       reset;
`ifdef FETCH_CTRL_STEP_EN
    logic       step;
`endif
    logic       run;
    logic       mem_ready;
    logic [7:0] mem_data;
    logic       exec_done;
    logic       jump;
    logic [7:0] jump_target;
    logic       mem_rd;
    logic       pc_noe;
    logic       pc_incr;
    logic       pc_load;
    logic [7:0] pc_data;
    logic [7:0] ir;
    logic       ir_valid;
    logic       halted;
    logic       fault;

    int  n_checks = 0;
    int  n_fails  = 0;
    int  cyc      = 0;
    ev_t exp_q[$];
    logic halted_q = 1'b0;

    fetch_ctrl #(
        .MEM_TIMEOUT   (15),
        .HALT_OPCODE   (8'hFF)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
`ifdef FETCH_CTRL_STEP_EN
        .i_step        (step),
`endif
        .i_run         (run),
        .i_mem_ready   (mem_ready),
        .i_mem_data    (mem_data),
        .i_exec_done   (exec_done),
        .i_jump        (jump),
        .i_jump_target (jump_target),
        .o_mem_rd      (mem_rd),
        .o_pc_noe      (pc_noe),
        .o_pc_incr     (pc_incr),
        .o_pc_load     (pc_load),
        .o_pc_data     (pc_data),
        .o_ir          (ir),
        .o_ir_valid    (ir_valid),
        .o_halted      (halted),
        .o_fault       (fault)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input ev_kind_t kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic scoreEvent(input ev_kind_t kind, input logic [7:0] data);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("[TB] FAIL unexpected_event: got kind %0d data %0h, expected none",
                     kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data) begin
                n_fails++;
                $display("[TB] FAIL event_order: got kind %0d data %0h, expected kind %0d data %0h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: samples on the falling edge, scores events and checks the
    // strobe exclusivity and bus-enable invariants every active cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (pc_incr)               scoreEvent(EV_INCR, 8'h00);
            if (ir_valid)              scoreEvent(EV_IRV, ir);
            if (pc_load)               scoreEvent(EV_LOAD, pc_data);
            if (halted && !halted_q)   scoreEvent(EV_HALT, {7'b0, fault});
            checkOutput("incr_load_exclusive", {31'b0, pc_incr & pc_load}, 32'd0);
            checkOutput("rd_implies_noe_low", {31'b0, mem_rd & pc_noe}, 32'd0);
        end
        halted_q <= halted;
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Advance one clock, then drive this cycle's inputs and let them settle.
    task automatic applyStimulus(input logic r, input logic rdy, input logic [7:0] d,
                                 input logic done, input logic j, input logic [7:0] tgt);
        nextCycle();
        run         = r;
        mem_ready   = rdy;
        mem_data    = d;
        exec_done   = done;
        jump        = j;
        jump_target = tgt;
        #1;
    endtask

    task automatic doReset();
        nextCycle();
        reset       = 1'b1;
        run         = 1'b0;
        mem_ready   = 1'b0;
        mem_data    = 8'h00;
        exec_done   = 1'b0;
        jump        = 1'b0;
        jump_target = 8'h00;
`ifdef FETCH_CTRL_STEP_EN
        step        = 1'b0;
`endif
        nextCycle();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int  first_addr;
        logic seen;

        reset = 1'b1;
        run = 1'b0; mem_ready = 1'b0; mem_data = 8'h00;
        exec_done = 1'b0; jump = 1'b0; jump_target = 8'h00;
`ifdef FETCH_CTRL_STEP_EN
        step = 1'b0;
`endif

        // Reset values, then a plain fetch of 8'h12 at full speed.
        doReset();
        checkOutput("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        checkOutput("rst_pc_noe", {31'b0, pc_noe}, 32'd1);
        checkOutput("rst_ir", {24'b0, ir}, 32'h00);
        checkOutput("rst_pc_data", {24'b0, pc_data}, 32'h00);
        checkOutput("rst_halted", {31'b0, halted}, 32'd0);
        checkOutput("rst_fault", {31'b0, fault}, 32'd0);
        checkOutput("rst_strobes", {29'b0, pc_incr, pc_load, ir_valid}, 32'd0);
        run = 1'b1;
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("addr_mem_rd", {31'b0, mem_rd}, 32'd1);
        checkOutput("addr_pc_noe", {31'b0, pc_noe}, 32'd0);
        first_addr = cyc;
        expectEvent(EV_INCR, 8'h00);
        expectEvent(EV_IRV, 8'h12);
        applyStimulus(1, 1, 8'h12, 0, 0, 8'h00);
        checkOutput("wait_pc_incr", {31'b0, pc_incr}, 32'd1);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("decode_ir", {24'b0, ir}, 32'h12);
        checkOutput("decode_ir_valid", {31'b0, ir_valid}, 32'd1);
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h00);
        checkOutput("exec_no_load", {31'b0, pc_load}, 32'd0);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("refetch_mem_rd", {31'b0, mem_rd}, 32'd1);
        checkOutput("fetch_to_fetch", cyc - first_addr, 32'd4);

        // Jump: i_jump alone is ignored, with done it loads 8'hA0.
        // i_run drops during DECODE and the instruction still completes.
        expectEvent(EV_INCR, 8'h00);
        expectEvent(EV_IRV, 8'h34);
        applyStimulus(1, 1, 8'h34, 0, 0, 8'h00);
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
        applyStimulus(0, 0, 8'h00, 0, 1, 8'hA0);
        checkOutput("jump_wo_done_load", {31'b0, pc_load}, 32'd0);
        checkOutput("jump_wo_done_data", {24'b0, pc_data}, 32'h00);
        expectEvent(EV_LOAD, 8'hA0);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'hA0);
        checkOutput("jump_load", {31'b0, pc_load}, 32'd1);
        checkOutput("jump_data", {24'b0, pc_data}, 32'hA0);
        checkOutput("jump_no_incr", {31'b0, pc_incr}, 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("idle_after_exec_rd", {31'b0, mem_rd}, 32'd0);
        checkOutput("idle_after_exec_noe", {31'b0, pc_noe}, 32'd1);
        checkOutput("ir_held", {24'b0, ir}, 32'h34);
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("idle_stays_idle", {31'b0, mem_rd}, 32'd0);

        // Reset in the third WAIT cycle clears IR and returns to IDLE.
        run = 1'b1;
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("wait3_mem_rd", {31'b0, mem_rd}, 32'd1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("midwait_rst_rd", {31'b0, mem_rd}, 32'd0);
        checkOutput("midwait_rst_noe", {31'b0, pc_noe}, 32'd1);
        checkOutput("midwait_rst_ir", {24'b0, ir}, 32'h00);

        // Fetching the halt opcode halts; toggling i_run does nothing.
        run = 1'b1;
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        expectEvent(EV_INCR, 8'h00);
        expectEvent(EV_IRV, 8'hFF);
        expectEvent(EV_HALT, 8'h00);
        applyStimulus(1, 1, 8'hFF, 0, 0, 8'h00);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("halt_op_ir_valid", {31'b0, ir_valid}, 32'd1);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("halt_op_halted", {31'b0, halted}, 32'd1);
        checkOutput("halt_op_fault", {31'b0, fault}, 32'd0);
        checkOutput("halt_op_noe", {31'b0, pc_noe}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i[0], 0, 8'h00, 0, 0, 8'h00);
            seen = seen | mem_rd;
        end
        checkOutput("halt_no_mem_rd", {31'b0, seen}, 32'd0);
        checkOutput("halt_sticky", {31'b0, halted}, 32'd1);

        // Memory never answers: fault on the 15th WAIT cycle.
        doReset();
        checkOutput("rst_clears_halt", {31'b0, halted}, 32'd0);
        run = 1'b1;
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        expectEvent(EV_HALT, 8'h01);
        seen = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
            seen = seen | pc_incr;
            if (i == 15) begin
                checkOutput("wait15_still_wait", {31'b0, mem_rd}, 32'd1);
                checkOutput("wait15_not_halted", {31'b0, halted}, 32'd0);
            end
        end
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("timeout_halted", {31'b0, halted}, 32'd1);
        checkOutput("timeout_fault", {31'b0, fault}, 32'd1);
        checkOutput("timeout_no_incr", {31'b0, seen}, 32'd0);
        checkOutput("timeout_no_rd", {31'b0, mem_rd}, 32'd0);

`ifdef FETCH_CTRL_STEP_EN
        // Single step with i_run low: one instruction, then back to IDLE.
        doReset();
        step = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
        step = 1'b0;
        checkOutput("step_addr_rd", {31'b0, mem_rd}, 32'd1);
        expectEvent(EV_INCR, 8'h00);
        expectEvent(EV_IRV, 8'h21);
        applyStimulus(0, 1, 8'h21, 0, 0, 8'h00);
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00);
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
        checkOutput("step_idle_rd", {31'b0, mem_rd}, 32'd0);
        checkOutput("step_idle_noe", {31'b0, pc_noe}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
            seen = seen | mem_rd;
        end
        checkOutput("step_single_only", {31'b0, seen}, 32'd0);
`endif

        nextCycle();
        nextCycle();
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max WAIT cycles before fault, range 1..255.
REQ-002 Parameter HALT_OPCODE, default 8'hFF: opcode that halts the sequencer.
REQ-003 i_clk  in  1  clock; reset i_reset, synchronous, active-high; clock i_clk.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 i_run  in  1  level; permits fetching of the next instruction.
REQ-006 i_mem_ready  in  1  memory data valid.
REQ-007 i_mem_data  in  8  instruction byte from memory.
REQ-008 i_exec_done  in  1  execute unit finished current instruction.
REQ-009 i_jump  in  1  qualifies i_exec_done; take branch.
REQ-010 i_jump_target  in  8  branch address.
REQ-011 o_mem_rd  out  1  memory read request.
REQ-012 o_pc_noe  out  1  PC address-bus enable, active-low.
REQ-013 o_pc_incr / o_pc_load  out  1 each  PC increment / PC load strobes.
REQ-014 o_pc_data  out  8  PC load value.
REQ-015 o_ir  out  8  instruction register; o_ir_valid  out  1  one-cycle decode strobe.
REQ-016 o_halted / o_fault  out  1 each  halt state / timeout fault flag.

Function
REQ-017 States IDLE, ADDR, WAIT, DECODE, EXEC, HALT; one transition per clock max.
REQ-018 IDLE: all strobes 0, o_pc_noe=1; i_run=1 -> ADDR next cycle.
REQ-019 ADDR: o_pc_noe=0, o_mem_rd=1; unconditionally -> WAIT.
REQ-020 WAIT: o_pc_noe=0, o_mem_rd=1 held; on i_mem_ready: o_ir<=i_mem_data, o_pc_incr=1 that cycle, -> DECODE.
REQ-021 WAIT counts cycles without i_mem_ready; count reaching MEM_TIMEOUT -> HALT, o_fault=1 sticky; o_pc_incr not asserted.
REQ-022 DECODE: o_ir_valid=1 exactly one cycle; o_ir==HALT_OPCODE -> HALT, else -> EXEC.
REQ-023 EXEC: wait for i_exec_done; i_jump ignored without i_exec_done.
REQ-024 EXEC with i_exec_done&i_jump: o_pc_load=1, o_pc_data=i_jump_target that cycle.
REQ-025 EXEC exit: i_run=1 -> ADDR, else -> IDLE; i_run dropping mid-fetch does not abort the instruction.
REQ-026 HALT: o_halted=1, all strobes 0, o_pc_noe=1; exits only on reset.
REQ-027 o_pc_incr and o_pc_load never asserted together; o_mem_rd=1 implies o_pc_noe=0.
REQ-028 Fetch-to-fetch minimum: 4 cycles (ADDR, WAIT with ready, DECODE, EXEC with done).

Reset
REQ-029 i_reset wins over every event, in every state, including mid-WAIT and mid-EXEC.
REQ-030 Reset values: state IDLE, o_ir=0, o_pc_data=0, counter 0, o_fault=0, o_halted=0, strobes 0, o_pc_noe=1.

Configuration
REQ-031 Macro FETCH_CTRL_STEP_EN adds input i_step (1 bit).
REQ-032 With macro: in IDLE, i_step=1 with i_run=0 fetches and executes exactly one instruction, then returns to IDLE.
REQ-033 Without macro: port i_step absent; only i_run starts fetch.

Structure
REQ-034 Package fetch_ctrl_pkg holds state enum fetch_state_t and default HALT opcode constant.
REQ-035 Sub-module fetch_watchdog: clear/enable inputs, timeout output, 8-bit counter.

Verification
REQ-036 Reset, i_run=1, ready on 1st WAIT cycle, data 8'h12, i_exec_done next EXEC cycle -> o_pc_incr one cycle, o_ir=8'h12, next ADDR 4 cycles after first.
REQ-037 EXEC with i_exec_done=1, i_jump=1, target 8'hA0 -> o_pc_load=1, o_pc_data=8'hA0, o_pc_incr=0 same cycle.
REQ-038 Memory data 8'hFF -> o_ir_valid pulse then o_halted=1; i_run toggled -> no o_mem_rd until reset.
REQ-039 i_mem_ready held 0 for 15 WAIT cycles -> o_fault=1, o_halted=1, no o_pc_incr.
REQ-040 i_reset during WAIT cycle 3 -> next cycle IDLE, o_mem_rd=0, o_pc_noe=1, o_ir=0.
REQ-041 FETCH_CTRL_STEP_EN defined, i_run=0, i_step pulse -> one full fetch/exec, then IDLE with o_mem_rd=0.
